matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Sequencer for the keyboard switch matrix. It drives one row at a time and waits a programmable settle time using an internal cycle counter. It then samples the columns, debounces every key with a per-key scan counter, and reports each debounced press or release as an event on a valid/ready handshake. It sits between the matrix I/O pins and the key-event consumer in the keyboard FPGA.

## Interface
- ROWS, default 8: number of matrix rows; 2 or more.
- COLS, default 8: number of matrix columns; 2 or more.
- SETTLE_CYCLES, default 16: cycles a row is driven before sampling; 1 or more.
- DEBOUNCE_SCANS, default 4: consecutive differing scans needed to flip a key state; 1 to 15.
- KEY_W, default $clog2(ROWS*COLS): width of the key index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  scan enable.
- row_n  out  ROWS  row drive, active-low; one-hot-low while scanning, all ones otherwise.
- col_n  in  COLS  column sense, active-low (0 = key closed); already synchronised externally.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_key  out  KEY_W  key index = row*COLS + col.
- evt_pressed  out  1  1 = debounced press, 0 = debounced release.
- scan_done  out  1  one-cycle pulse at the end of each full matrix scan.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, EMIT, NEXT. Internal row counter r, column counter c, settle counter s.
- IDLE:
  - row_n is all ones.
  - If en=1, set r=0 and go to DRIVE.
- DRIVE:
  - row_n[r]=0; all other rows are 1.
  - s counts 0..SETTLE_CYCLES-1, then the FSM goes to SAMPLE.
- SAMPLE:
  - Capture ~col_n into raw[COLS-1:0].
  - Set c=0, then go to EMIT.
- EMIT processes one column per cycle. A column is processed only when evt_valid=0, or when evt_valid=1 and evt_ready=1 in the same cycle. For key k=r*COLS+c:
  - If raw[c]==stable[k]: cnt[k]=0.
  - Else if cnt[k]==DEBOUNCE_SCANS-1: flip stable[k], set cnt[k]=0, and load the event evt_key=k, evt_pressed=new stable[k], evt_valid=1.
  - Else: cnt[k]++.
  - After c=COLS-1 is processed, go to NEXT.
- NEXT:
  - Advance r. Wrap from ROWS-1 to 0 and pulse scan_done.
  - If en=1, go to DRIVE; otherwise go to IDLE.
  - en is sampled only in NEXT, so a row in progress always completes.
- Handshake:
  - An event transfers when evt_valid and evt_ready are both 1.
  - While evt_valid=1 and evt_ready=0, evt_key and evt_pressed hold stable, and EMIT stalls with row_n unchanged.
  - evt_valid drops after the transfer unless a new event loads in the same cycle (back-to-back transfer).
  - A pending event stays valid in IDLE until it is accepted.
- Width rules:
  - cnt[k] is 4 bits.
  - stable has ROWS*COLS bits and is all 0 (released) after reset.
  - r, c and s saturate nowhere; they wrap only as stated above.

## Timing
- Reset values: row_n=all ones, evt_valid=0, evt_key=0, evt_pressed=0, scan_done=0, state=IDLE, stable=0, cnt=0.
- Row period without stalls is SETTLE_CYCLES+COLS+2 cycles: DRIVE SETTLE_CYCLES, SAMPLE 1, EMIT COLS, NEXT 1.
- Full scan period is ROWS times the row period. IDLE is left in the cycle after en is seen high, giving 1 cycle of latency to the first row drive.
- A key held from scan n produces its event in scan n+DEBOUNCE_SCANS-1, in the EMIT cycle for its column. evt_valid rises on the following clock edge.
- Reset asserted mid-operation clears all state immediately and asynchronously. Any pending event is dropped, and no event is produced for keys that were mid-debounce.
- Simultaneous events on one row are emitted in ascending column order, one per accepted handshake.

## Test plan
Configuration for all scenarios: ROWS=4, COLS=4, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3.
- Reset check: assert rst with en=1 and col_n=1111 -> all outputs hold their reset values; row_n=1111.
- Idle scan timing: en=1, evt_ready=1, no keys pressed -> row_n steps 1110, 1101, 1011, 0111 with 8 cycles each; scan_done pulses every 32 cycles; evt_valid stays 0.
- Press and release: hold row1/col2 closed -> one event key=6, pressed=1 in the 3rd scan; release it -> one event key=6, pressed=0 three scans later.
- Bounce rejection: close the key for 2 scans, then open it -> no event; cnt returns to 0.
- Backpressure: evt_ready=0, press row2/col0 and row2/col3 together -> event key=8 held stable while row_n stays 1011 and scan_done is absent. Raise evt_ready -> key=11 follows, and the scan resumes.
- Mid-operation reset and en drop: pulse rst while evt_valid=1 -> evt_valid=0 at once, no event afterwards. Separately, drop en during row 1 DRIVE -> row 1 completes, then row_n=1111 and the FSM is in IDLE.

Source files
------------

// File: rtl/matrix_scan_ctrl_if.sv
// Key-event handshake between the matrix scanner and its consumer.
interface matrix_scan_ctrl_if #(
  parameter int KEY_W = 6
);
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic             evt_pressed;

  modport master (output evt_valid, output evt_key, output evt_pressed, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_pressed, output evt_ready);
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Keyboard matrix scanner: drives rows one at a time, debounces every key
// with a per-key scan counter and emits press/release events.
module matrix_scan_ctrl #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int KEY_W          = $clog2(ROWS*COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [ROWS-1:0]     row_n,
  input  logic [COLS-1:0]     col_n,
  matrix_scan_ctrl_if.master  evt,
  output logic                scan_done
);

  localparam int NK = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(COLS - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DB_LAST = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, EMIT, NEXT} state_t;

  state_t           state;
  logic [RW-1:0]    r;
  logic [RW-1:0]    r_next;
  logic [CW-1:0]    c;
  logic [SW-1:0]    s;
  logic [COLS-1:0]  raw;
  logic [NK-1:0]    stable;
  logic [3:0]       cnt [NK];
  logic [KEY_W-1:0] k;
  logic             valid_q;
  logic [KEY_W-1:0] key_q;
  logic             pressed_q;
  logic             advance;

  assign evt.evt_valid   = valid_q;
  assign evt.evt_key     = key_q;
  assign evt.evt_pressed = pressed_q;

  always_comb begin
    k       = KEY_W'(32'(r) * 32'(COLS) + 32'(c));
    r_next  = (r == R_LAST) ? '0 : r + 1'b1;
    // A column may only be processed when the output slot is free or emptying.
    advance = !valid_q || evt.evt_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      s         <= '0;
      raw       <= '0;
      row_n     <= '1;
      stable    <= '0;
      for (int unsigned i = 0; i < NK; i++) cnt[i] <= '0;
      valid_q   <= 1'b0;
      key_q     <= '0;
      pressed_q <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (valid_q && evt.evt_ready) valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            r     <= '0;
            s     <= '0;
            row_n <= ~ROWS'(1);
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (s == S_LAST) begin
            s     <= '0;
            state <= SAMPLE;
          end else begin
            s <= s + 1'b1;
          end
        end
        SAMPLE: begin
          raw   <= ~col_n;
          c     <= '0;
          state <= EMIT;
        end
        EMIT: begin
          if (advance) begin
            if (raw[c] == stable[k]) begin
              cnt[k] <= '0;
            end else if (cnt[k] == DB_LAST) begin
              stable[k] <= raw[c];
              cnt[k]    <= '0;
              valid_q   <= 1'b1;
              key_q     <= k;
              pressed_q <= raw[c];
            end else begin
              cnt[k] <= cnt[k] + 4'd1;
            end
            if (c == C_LAST) state <= NEXT;
            else             c     <= c + 1'b1;
          end
        end
        NEXT: begin
          r <= r_next;
          if (r == R_LAST) scan_done <= 1'b1;
          if (en) begin
            row_n <= ~(ROWS'(1) << r_next);
            state <= DRIVE;
          end else begin
            row_n <= '1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl on a 4x4 matrix with a modelled key array.
module tb_matrix_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        scan_done;
  logic [15:0] keys = '0;
  logic [3:0]  exp_row;

  matrix_scan_ctrl_if #(.KEY_W(4)) evt_bus ();

  matrix_scan_ctrl #(
    .ROWS(4), .COLS(4), .SETTLE_CYCLES(2), .DEBOUNCE_SCANS(3), .KEY_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .row_n(row_n), .col_n(col_n),
    .evt(evt_bus), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Closed key pulls its column low only while its row is driven.
  always_comb begin
    col_n = '1;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!row_n[rr] && keys[rr*4+cc]) col_n[cc] = 1'b0;
  end

  typedef struct packed {
    logic [3:0] key;
    logic       pressed;
  } evt_t;

  evt_t exp_q[$];
  evt_t got_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_evt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && evt_bus.evt_valid && evt_bus.evt_ready) begin
      n_evt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL evt_unexpected: got key %0d pressed %0d expected none",
                 evt_bus.evt_key, evt_bus.evt_pressed);
      end else begin
        got_e = exp_q.pop_front();
        check("evt_key", 32'(evt_bus.evt_key), 32'(got_e.key));
        check("evt_pressed", 32'(evt_bus.evt_pressed), 32'(got_e.pressed));
      end
    end
  end

  task automatic wait_scans(input int n);
    int seen = 0;
    for (int i = 0; i < 40*n + 10 && seen < n; i++) begin
      @(negedge clk);
      if (scan_done) seen++;
    end
    check("scan_done_timeout", 32'(seen), 32'(n));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !evt_bus.evt_valid; i++) @(negedge clk);
    check("evt_valid_seen", 32'(evt_bus.evt_valid), 32'd1);
  endtask

  task automatic key_event(input int key, input logic val);
    keys[key] = val;
    exp_q.push_back(evt_t'{key: 4'(key), pressed: val});
    wait_scans(2);
    #1 check("pending_before_scan3", 32'(exp_q.size()), 32'd1);
    wait_scans(1);
    #1 check("drained_in_scan3", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int ev0;
    int len;
    evt_bus.evt_ready = 1'b1;

    // Reset values with en high and no keys
    repeat (2) @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'hF);
    check("rst_valid", 32'(evt_bus.evt_valid), 32'd0);
    check("rst_key", 32'(evt_bus.evt_key), 32'd0);
    check("rst_pressed", 32'(evt_bus.evt_pressed), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Idle scan timing over two full scans
    for (int i = 0; i < 10 && row_n != 4'b1110; i++) @(negedge clk);
    for (int n = 0; n < 64; n++) begin
      if (n > 0) @(negedge clk);
      exp_row = ~(4'b0001 << ((n / 8) % 4));
      check("idle_row_n", 32'(row_n), 32'(exp_row));
      check("idle_scan_done", 32'(scan_done), 32'(n == 32));
      check("idle_valid", 32'(evt_bus.evt_valid), 32'd0);
    end

    // Press and release key 6
    wait_scans(1);
    key_event(6, 1'b1);
    key_event(6, 1'b0);

    // Bounce: closed for two scans only
    ev0 = n_evt;
    keys[6] = 1'b1;
    wait_scans(2);
    keys[6] = 1'b0;
    wait_scans(3);
    #1 check("bounce_no_evt", 32'(n_evt), 32'(ev0));
    key_event(6, 1'b1);
    key_event(6, 1'b0);

    // Backpressure on two keys in row 2
    #1 evt_bus.evt_ready = 1'b0;
    keys[8] = 1'b1;
    keys[11] = 1'b1;
    exp_q.push_back(evt_t'{key: 4'd8, pressed: 1'b1});
    exp_q.push_back(evt_t'{key: 4'd11, pressed: 1'b1});
    wait_scans(2);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(evt_bus.evt_valid), 32'd1);
      check("bp_key", 32'(evt_bus.evt_key), 32'd8);
      check("bp_pressed", 32'(evt_bus.evt_pressed), 32'd1);
      check("bp_row_n", 32'(row_n), 32'b1011);
      check("bp_scan_done", 32'(scan_done), 32'd0);
    end
    @(posedge clk); #1 evt_bus.evt_ready = 1'b1;
    wait_scans(1);
    #1 check("bp_drained", 32'(exp_q.size()), 32'd0);
    keys[8] = 1'b0;
    keys[11] = 1'b0;
    exp_q.push_back(evt_t'{key: 4'd8, pressed: 1'b0});
    exp_q.push_back(evt_t'{key: 4'd11, pressed: 1'b0});
    wait_scans(3);
    #1 check("release_drained", 32'(exp_q.size()), 32'd0);

    // Reset while an event is pending
    evt_bus.evt_ready = 1'b0;
    keys[6] = 1'b1;
    wait_scans(2);
    wait_valid();
    @(posedge clk); #1 rst = 1'b1;
    keys = '0;
    #1;
    check("midrst_valid", 32'(evt_bus.evt_valid), 32'd0);
    check("midrst_row_n", 32'(row_n), 32'hF);
    check("midrst_key", 32'(evt_bus.evt_key), 32'd0);
    #2 evt_bus.evt_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ev0 = n_evt;
    wait_scans(4);
    #1 check("no_evt_after_rst", 32'(n_evt), 32'(ev0));

    // Drop en during row 1 DRIVE
    for (int i = 0; i < 40 && row_n != 4'b1101; i++) @(negedge clk);
    check("row1_reached", 32'(row_n), 32'b1101);
    len = 1;
    @(posedge clk); #1 en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_n != 4'b1101) break;
      len++;
    end
    check("row1_len", 32'(len), 32'd8);
    for (int i = 0; i < 10; i++) begin
      check("idle_after_en_drop", 32'(row_n), 32'hF);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
